// File: rtl/flappy_bird_physics.sv
// flappy_bird_physics: single-bird flight physics with signed velocity,
// gravity, edge-detected flaps, terminal-velocity clamp, ceiling clamp and
// floor-collision death. Optional flap lockout is enabled with the
// FLAP_COOLDOWN_EN macro.
`timescale 1ns/1ps
module flappy_bird_physics #(
  parameter int YW             = 10,
  parameter int XW             = 10,
  parameter int VW             = 6,
  parameter int X_START        = 500,
  parameter int Y_START        = 100,
  parameter int Y_MIN          = 0,
  parameter int Y_MAX          = 460,
  parameter int TICK_DIV       = 2000000,
  parameter int GRAV           = 1,
  parameter int FLAP_V         = 15,
  parameter int V_MAX          = 15,
  parameter int COOLDOWN_TICKS = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Flap_Button,
  output logic [YW-1:0]        YBird,
  output logic [XW-1:0]        XBird,
  output logic signed [VW-1:0] Vel,
  output logic                 Alive,
  output logic                 Dead,
  output logic                 Tick
);

  localparam int                     CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]          CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic signed [YW+1:0]   Y_LO     = (YW+2)'(Y_MIN);
  localparam logic signed [YW+1:0]   Y_HI     = (YW+2)'(Y_MAX);
  localparam logic signed [VW:0]     V_TOP    = (VW+1)'(V_MAX);
  localparam logic signed [VW:0]     V_GRAV   = (VW+1)'(GRAV);
  localparam logic signed [VW-1:0]   V_FLAP   = VW'(-FLAP_V);

  typedef enum logic [1:0] {IDLE, FLY, DEAD} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  flap_prev;
  logic                  flap_ok;
  logic signed [YW+1:0]  y_next;
  logic signed [VW:0]    v_inc;
  logic signed [VW-1:0]  v_fall;

`ifdef FLAP_COOLDOWN_EN
  localparam int LW = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;
  logic [LW-1:0] lock;
`endif

  assign XBird = XW'(X_START);

  // Tick decode, candidate position, gravity with terminal clamp, flap acceptance
  always_comb begin
    Tick    = (state == FLY) && (cnt == CNT_LAST);
    y_next  = $signed({2'b00, YBird}) + (YW+2)'(Vel);
    v_inc   = (VW+1)'(Vel) + V_GRAV;
    v_fall  = (v_inc > V_TOP) ? V_TOP[VW-1:0] : v_inc[VW-1:0];
    flap_ok = Flap_Button && !flap_prev && (state == FLY);
`ifdef FLAP_COOLDOWN_EN
    flap_ok = flap_ok && (lock == '0);
`endif
  end

  // State machine and physics registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      YBird     <= YW'(Y_START);
      Vel       <= '0;
      cnt       <= '0;
      flap_prev <= 1'b0;
      Alive     <= 1'b0;
      Dead      <= 1'b0;
    end else begin
      flap_prev <= Flap_Button;
      if (!Start) begin
        state <= IDLE;
        YBird <= YW'(Y_START);
        Vel   <= '0;
        cnt   <= '0;
        Alive <= 1'b0;
        Dead  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= FLY;
            Alive <= 1'b1;
            Dead  <= 1'b0;
          end
          FLY: begin
            cnt <= Tick ? '0 : cnt + 1'b1;
            if (Tick) begin
              if (y_next >= Y_HI) begin
                YBird <= Y_HI[YW-1:0];
                Vel   <= '0;
                state <= DEAD;
                Alive <= 1'b0;
                Dead  <= 1'b1;
              // Clamp only while moving upward; a bird resting at the
              // ceiling with zero velocity must still pick up gravity.
              end else if ((y_next <= Y_LO) && Vel[VW-1]) begin
                YBird <= Y_LO[YW-1:0];
                Vel   <= flap_ok ? V_FLAP : '0;
              end else begin
                YBird <= y_next[YW-1:0];
                Vel   <= flap_ok ? V_FLAP : v_fall;
              end
            end else if (flap_ok) begin
              Vel <= V_FLAP;
            end
          end
          DEAD: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef FLAP_COOLDOWN_EN
  // Flap lockout: reload on accepted flap, count down on ticks
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lock <= '0;
    end else if (!Start || (state == IDLE)) begin
      lock <= '0;
    end else if (flap_ok) begin
      lock <= LW'(COOLDOWN_TICKS);
    end else if (Tick && (lock != '0)) begin
      lock <= lock - 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_flappy_bird_physics.sv
// Self-checking bench for flappy_bird_physics with a cycle scoreboard driven
// by a reference model of the flight rules.
`timescale 1ns/1ps
module tb_flappy_bird_physics;

  localparam int TDIV = 4;
  localparam int YS   = 100;
  localparam int YMIN = 0;
  localparam int YMAX = 460;
  localparam int GR   = 1;
  localparam int FV   = 15;
  localparam int VMAX = 15;
  localparam int CD   = 4;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Start;
  logic              Flap_Button;
  logic [9:0]        YBird;
  logic [9:0]        XBird;
  logic signed [5:0] Vel;
  logic              Alive;
  logic              Dead;
  logic              Tick;

  flappy_bird_physics #(.TICK_DIV(TDIV)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .Flap_Button (Flap_Button),
    .YBird       (YBird),
    .XBird       (XBird),
    .Vel         (Vel),
    .Alive       (Alive),
    .Dead        (Dead),
    .Tick        (Tick)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [18:0] sb[$];

  // reference model state: 0 IDLE, 1 FLY, 2 DEAD
  int m_state, m_y, m_v, m_cnt, m_lock;
  bit m_prev, m_ticked;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_y = YS; m_v = 0; m_cnt = 0; m_lock = 0;
    m_prev = 1'b0; m_ticked = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit f);
    bit tk, fl;
    int yn, vn;
    tk = (m_state == 1) && (m_cnt == TDIV - 1);
    fl = f && !m_prev && (m_state == 1);
`ifdef FLAP_COOLDOWN_EN
    fl = fl && (m_lock == 0);
`endif
    m_prev   = f;
    m_ticked = tk && s;
    if (!s) begin
      m_state = 0; m_y = YS; m_v = 0; m_cnt = 0; m_lock = 0;
    end else if (m_state == 0) begin
      m_state = 1; m_lock = 0;
    end else if (m_state == 1) begin
      m_cnt = tk ? 0 : m_cnt + 1;
      if (fl) m_lock = CD;
      else if (tk && m_lock > 0) m_lock--;
      if (tk) begin
        yn = m_y + m_v;
        if (yn >= YMAX) begin
          m_y = YMAX; m_v = 0; m_state = 2;
        end else begin
          if (yn <= YMIN && m_v < 0) begin
            m_y = YMIN; vn = 0;
          end else begin
            m_y = yn;
            vn = (m_v + GR > VMAX) ? VMAX : m_v + GR;
          end
          m_v = fl ? -FV : vn;
        end
      end else if (fl) begin
        m_v = -FV;
      end
    end
  endtask

  function automatic logic [18:0] exp_vec();
    logic [5:0] v6;
    logic [9:0] y10;
    logic t, d, a;
    v6  = 6'(m_v);
    y10 = 10'(m_y);
    t   = (m_state == 1) && (m_cnt == TDIV - 1);
    d   = (m_state == 2);
    a   = (m_state == 1);
    return {t, d, a, v6, y10};
  endfunction

  task automatic cyc(input bit s, input bit f);
    logic [18:0] got;
    Start       = s;
    Flap_Button = f;
    model_step(s, f);
    sb.push_back(exp_vec());
    @(posedge Clk);
    #1;
    got = {Tick, Dead, Alive, Vel, YBird};
    if (sb.size() == 0) check("sb_empty", 0, 1);
    else check("cyc", int'(got), int'(sb.pop_front()));
  endtask

  task automatic run_to_tick();
    for (int i = 0; i < 2 * TDIV; i++) begin
      cyc(1'b1, 1'b0);
      if (m_ticked) return;
    end
    check("tick_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; Flap_Button = 1'b0;
    model_reset();
    #12;
    check("rst_y", YBird, YS);
    check("rst_x", XBird, 500);
    check("rst_v", Vel, 0);
    check("rst_alive", Alive, 0);
    check("rst_dead", Dead, 0);
    check("rst_tick", Tick, 0);
    @(negedge Clk) Reset = 1'b0;
    #1;

    // idle, then free fall from spawn
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    repeat (13) cyc(1'b1, 1'b0);
    check("fall_y", YBird, 103);
    check("fall_v", Vel, 3);

    // held button: one flap only
    repeat (4) cyc(1'b1, 1'b1);
    check("flap_y", YBird, 88);
    check("flap_v", Vel, -14);
    repeat (16) cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);

    // climb into the ceiling
    for (int i = 0; i < 12; i++) begin
      run_to_tick();
      if (m_y == 0) break;
      cyc(1'b1, 1'b1);
      cyc(1'b1, 1'b0);
    end
    check("ceil_y", YBird, 0);
    check("ceil_v", Vel, 0);
    check("ceil_alive", Alive, 1);
    run_to_tick();
    check("ceil_next_y", YBird, 0);
    check("ceil_next_v", Vel, 1);

    // terminal velocity
    repeat (20) run_to_tick();
    check("term_y", YBird, 195);
    check("term_v", Vel, 15);

    // flap coincident with tick
    for (int i = 0; i < TDIV && m_cnt != TDIV - 1; i++) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    check("cotick_y", YBird, 210);
    check("cotick_v", Vel, -15);
    cyc(1'b1, 1'b0);

    // fall to the floor
    for (int i = 0; i < 80 && m_state != 2; i++) run_to_tick();
    check("floor_y", YBird, YMAX);
    check("floor_dead", Dead, 1);
    check("floor_alive", Alive, 0);
    check("floor_v", Vel, 0);
    for (int i = 0; i < 40; i++) cyc(1'b1, i[1]);
    check("frozen_y", YBird, YMAX);
    check("frozen_dead", Dead, 1);
    cyc(1'b0, 1'b0);
    check("idle_y", YBird, YS);
    check("idle_dead", Dead, 0);

    // asynchronous reset mid-flight
    cyc(1'b1, 1'b0);
    run_to_tick();
    run_to_tick();
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    #3;
    Reset = 1'b1;
    #1;
    check("arst_y", YBird, YS);
    check("arst_v", Vel, 0);
    check("arst_alive", Alive, 0);
    check("arst_tick", Tick, 0);
    model_reset();
    sb.delete();
    @(negedge Clk) Reset = 1'b0;

    // flap spacing (lockout when enabled)
    cyc(1'b1, 1'b0);
    run_to_tick();
    run_to_tick();
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    run_to_tick();
    run_to_tick();
    cyc(1'b1, 1'b1);
`ifdef FLAP_COOLDOWN_EN
    check("cool_ignored_v", Vel, -13);
`else
    check("second_flap_v", Vel, -15);
`endif
    cyc(1'b1, 1'b0);
    repeat (5) run_to_tick();
    cyc(1'b1, 1'b1);
    check("late_flap_v", Vel, -15);
    cyc(1'b1, 1'b0);
    repeat (2) run_to_tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
